// File: rtl/hft_pkg.sv
// rtl/hft_pkg.sv - shared constants and FSM state types for the message ingress path
package hft_pkg;

  localparam int REG_WIDTH     = 32;
  localparam int WORDS_PER_MSG = 8;

  typedef enum logic {
    ASM_COLLECT,
    ASM_DISCARD
  } asm_state_t;

  typedef enum logic {
    ISS_IDLE,
    ISS_GAP
  } iss_state_t;

endpackage

// File: rtl/ingress_frame_buf.sv
// rtl/ingress_frame_buf.sv - frame FIFO: word-granular writes, frame-wide reads, owns pointers and count
module ingress_frame_buf #(
  parameter int REG_WIDTH   = hft_pkg::REG_WIDTH,
  parameter int WORDS       = hft_pkg::WORDS_PER_MSG,
  parameter int FRAME_DEPTH = 4,
  localparam int IDX_W      = $clog2(WORDS),
  localparam int CNT_W      = $clog2(FRAME_DEPTH + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_wr_en,
  input  logic [IDX_W-1:0]                i_wr_idx,
  input  logic [REG_WIDTH-1:0]            i_wr_data,
  input  logic                            i_commit,
  input  logic                            i_pop,
  output logic [WORDS-1:0][REG_WIDTH-1:0] o_rd_frame,
  output logic [CNT_W-1:0]                o_count,
  output logic                            o_ready
);

  localparam int                PTR_W   = $clog2(FRAME_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FRAME_DEPTH);

  logic [REG_WIDTH-1:0] slot_q [FRAME_DEPTH][WORDS];
  logic [REG_WIDTH-1:0] slot_d [FRAME_DEPTH][WORDS];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ready_q, ready_d;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_wr_en) begin
      slot_d[wr_ptr_q][i_wr_idx] = i_wr_data;
    end
    if (i_commit) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({i_commit, i_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Registered from the next count so a full FIFO refuses words on the very next cycle.
    ready_d = (count_d < DEPTH_C);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slot_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    for (int w = 0; w < WORDS; w++) begin
      o_rd_frame[w] = slot_q[rd_ptr_q][w];
    end
  end

  assign o_count = count_q;
  assign o_ready = ready_q;

endmodule

// File: rtl/msg_ingress.sv
// rtl/msg_ingress.sv - assembles 8-word messages, buffers whole frames and issues them to the parser
module msg_ingress #(
  parameter int  REG_WIDTH   = hft_pkg::REG_WIDTH,
  parameter int  FRAME_DEPTH = 4,
  localparam int CNT_W       = $clog2(FRAME_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [REG_WIDTH-1:0] i_word,
  input  logic                 i_word_valid,
  input  logic                 i_word_last,
  output logic                 o_word_ready,
  input  logic                 i_book_is_busy,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic [REG_WIDTH-1:0] o_reg_4,
  output logic [REG_WIDTH-1:0] o_reg_5,
  output logic [REG_WIDTH-1:0] o_reg_6,
  output logic [REG_WIDTH-1:0] o_reg_7,
  output logic [REG_WIDTH-1:0] o_reg_8,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic [CNT_W-1:0]     o_frame_count
);

  import hft_pkg::*;

  localparam int               IDX_W    = $clog2(WORDS_PER_MSG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_MSG - 1);

  typedef logic [WORDS_PER_MSG-1:0][REG_WIDTH-1:0] frame_t;

  asm_state_t       asm_q, asm_d;
  iss_state_t       iss_q, iss_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  frame_t           regs_q, regs_d;

  logic             word_ready;
  logic             accept;
  logic             wr_en;
  logic             commit;
  logic             pop;
  frame_t           rd_frame;
  logic [CNT_W-1:0] count;

  assign accept = i_word_valid && word_ready;

  // Dropped words still land in the open slot; they are overwritten before that slot is ever committed.
  always_comb begin
    asm_d  = asm_q;
    idx_d  = idx_q;
    err_d  = 1'b0;
    wr_en  = 1'b0;
    commit = 1'b0;
    unique case (asm_q)
      ASM_COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (i_word_last) begin
              commit = 1'b1;
            end else begin
              err_d = 1'b1;
              asm_d = ASM_DISCARD;
            end
          end else if (i_word_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ASM_DISCARD: begin
        if (accept && i_word_last) begin
          asm_d = ASM_COLLECT;
          idx_d = '0;
        end
      end
      default: asm_d = ASM_COLLECT;
    endcase
  end

  // The gap state gives the order book a cycle to raise busy before the next issue.
  always_comb begin
    iss_d   = iss_q;
    regs_d  = regs_q;
    valid_d = 1'b0;
    pop     = 1'b0;
    unique case (iss_q)
      ISS_IDLE: begin
        if ((count != '0) && !i_book_is_busy) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          regs_d  = rd_frame;
          iss_d   = ISS_GAP;
        end
      end
      ISS_GAP: iss_d = ISS_IDLE;
      default: iss_d = ISS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      asm_q   <= ASM_COLLECT;
      iss_q   <= ISS_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      regs_q  <= '0;
    end else begin
      asm_q   <= asm_d;
      iss_q   <= iss_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      regs_q  <= regs_d;
    end
  end

  ingress_frame_buf #(
    .REG_WIDTH   (REG_WIDTH),
    .WORDS       (WORDS_PER_MSG),
    .FRAME_DEPTH (FRAME_DEPTH)
  ) u_frame_buf (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wr_en    (wr_en),
    .i_wr_idx   (idx_q),
    .i_wr_data  (i_word),
    .i_commit   (commit),
    .i_pop      (pop),
    .o_rd_frame (rd_frame),
    .o_count    (count),
    .o_ready    (word_ready)
  );

  assign o_word_ready  = word_ready;
  assign o_frame_count = count;
  assign o_valid       = valid_q;
  assign o_frame_err   = err_q;
  assign o_reg_1       = regs_q[0];
  assign o_reg_2       = regs_q[1];
  assign o_reg_3       = regs_q[2];
  assign o_reg_4       = regs_q[3];
  assign o_reg_5       = regs_q[4];
  assign o_reg_6       = regs_q[5];
  assign o_reg_7       = regs_q[6];
  assign o_reg_8       = regs_q[7];

endmodule

// File: tb/tb_msg_ingress.sv
// tb/tb_msg_ingress.sv - directed self-checking bench for msg_ingress
module tb_msg_ingress;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_word;
  logic        i_word_valid;
  logic        i_word_last;
  logic        o_word_ready;
  logic        i_book_is_busy;
  logic [31:0] o_reg_1, o_reg_2, o_reg_3, o_reg_4, o_reg_5, o_reg_6, o_reg_7, o_reg_8;
  logic        o_valid;
  logic        o_frame_err;
  logic [2:0]  o_frame_count;

  msg_ingress #(.REG_WIDTH(32), .FRAME_DEPTH(4)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_word         (i_word),
    .i_word_valid   (i_word_valid),
    .i_word_last    (i_word_last),
    .o_word_ready   (o_word_ready),
    .i_book_is_busy (i_book_is_busy),
    .o_reg_1        (o_reg_1),
    .o_reg_2        (o_reg_2),
    .o_reg_3        (o_reg_3),
    .o_reg_4        (o_reg_4),
    .o_reg_5        (o_reg_5),
    .o_reg_6        (o_reg_6),
    .o_reg_7        (o_reg_7),
    .o_reg_8        (o_reg_8),
    .o_valid        (o_valid),
    .o_frame_err    (o_frame_err),
    .o_frame_count  (o_frame_count)
  );

  always #5 i_clk = ~i_clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           err_cnt = 0;
  int           err_cyc = 0;
  logic [255:0] fq[$];
  int           fcyc[$];
  bit           sender_done;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_valid) begin
        fq.push_back({o_reg_8, o_reg_7, o_reg_6, o_reg_5, o_reg_4, o_reg_3, o_reg_2, o_reg_1});
        fcyc.push_back(cyc);
      end
      if (o_frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int guard = 0;
    i_word       = d;
    i_word_valid = 1'b1;
    i_word_last  = last;
    while (o_word_ready !== 1'b1 && guard < 500) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (guard >= 500) check_eq("word_ready_timeout", {63'd0, o_word_ready}, 64'd1);
    @(posedge i_clk); #1;
    acc_cyc      = cyc;
    i_word_valid = 1'b0;
    i_word_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base);
    for (int k = 0; k < 8; k++) send_word(base + k, (k == 7));
  endtask

  task automatic wait_frames(input int target);
    int g = 0;
    while (fq.size() < target && g < 300) begin
      @(posedge i_clk); #1;
      g++;
    end
    if (fq.size() < target) check_eq("frame_timeout", fq.size(), target);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [31:0] base);
    if (idx >= fq.size()) begin
      check_eq({tag, "_missing"}, fq.size(), idx + 1);
    end else begin
      for (int k = 0; k < 8; k++) check_eq(tag, fq[idx][32*k +: 32], base + k);
    end
  endtask

  int b, e0, ta, t8, g;

  initial begin
    i_reset_n      = 1'b0;
    i_word         = '0;
    i_word_valid   = 1'b0;
    i_word_last    = 1'b0;
    i_book_is_busy = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_err", o_frame_err, 0);
    check_eq("rst_count", o_frame_count, 0);
    check_eq("rst_ready", o_word_ready, 0);
    check_eq("rst_reg1", o_reg_1, 0);
    check_eq("rst_reg8", o_reg_8, 0);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    check_eq("ready_after_rst", o_word_ready, 1);

    // single good frame
    b = fq.size();
    send_frame(32'h11);
    ta = acc_cyc;
    wait_frames(b + 1);
    repeat (4) @(posedge i_clk);
    #1;
    check_eq("single_nframes", fq.size(), b + 1);
    check_frame("single_data", b, 32'h11);
    if (fq.size() > b) check_eq("single_latency", fcyc[b] - ta, 1);
    check_eq("single_count", o_frame_count, 0);

    // short frame, then good frame
    e0 = err_cnt;
    b  = fq.size();
    send_word(32'h31, 1'b0);
    send_word(32'h32, 1'b0);
    send_word(32'h33, 1'b1);
    ta = acc_cyc;
    send_frame(32'hA1);
    wait_frames(b + 1);
    repeat (4) @(posedge i_clk);
    #1;
    check_eq("short_errs", err_cnt - e0, 1);
    check_eq("short_err_timing", err_cyc - ta, 0);
    check_eq("short_nframes", fq.size(), b + 1);
    check_frame("short_next", b, 32'hA1);

    // long frame, then good frame
    e0 = err_cnt;
    b  = fq.size();
    t8 = 0;
    for (int k = 0; k < 10; k++) begin
      send_word(32'h51 + k, (k == 9));
      if (k == 7) t8 = acc_cyc;
    end
    send_frame(32'hB1);
    wait_frames(b + 1);
    repeat (4) @(posedge i_clk);
    #1;
    check_eq("long_errs", err_cnt - e0, 1);
    check_eq("long_err_timing", err_cyc - t8, 0);
    check_eq("long_nframes", fq.size(), b + 1);
    check_frame("long_next", b, 32'hB1);

    // full FIFO with busy held, then drain
    i_book_is_busy = 1'b1;
    b = fq.size();
    sender_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 5; f++) send_frame(((f + 1) << 8) | 1);
        sender_done = 1'b1;
      end
    join_none
    g = 0;
    while (o_frame_count != 3'd4 && g < 400) begin
      @(negedge i_clk);
      g++;
    end
    check_eq("full_count", o_frame_count, 4);
    check_eq("full_ready", o_word_ready, 0);
    repeat (10) @(posedge i_clk);
    #1;
    check_eq("busy_no_issue", fq.size() - b, 0);
    check_eq("full_ready_held", o_word_ready, 0);
    i_book_is_busy = 1'b0;
    wait_frames(b + 5);
    g = 0;
    while (!sender_done && g < 400) begin
      @(posedge i_clk); #1;
      g++;
    end
    check_eq("full_sender_done", sender_done, 1);
    for (int f = 0; f < 5; f++) check_frame("full_order", b + f, ((f + 1) << 8) | 1);
    if (fq.size() >= b + 4) begin
      for (int i = 0; i < 3; i++) check_eq("drain_spacing", fcyc[b + i + 1] - fcyc[b + i], 2);
    end
    repeat (4) @(posedge i_clk);
    #1;
    check_eq("drain_count", o_frame_count, 0);

    // commit and issue on the same edge with one frame buffered
    i_book_is_busy = 1'b1;
    b = fq.size();
    send_frame(32'h601);
    for (int k = 0; k < 7; k++) send_word(32'h701 + k, 1'b0);
    check_eq("simul_pre_count", o_frame_count, 1);
    i_book_is_busy = 1'b0;
    send_word(32'h708, 1'b1);
    check_eq("simul_count", o_frame_count, 1);
    check_eq("simul_valid", o_valid, 1);
    check_eq("simul_reg1", o_reg_1, 32'h601);
    wait_frames(b + 2);
    check_frame("simul_first", b, 32'h601);
    check_frame("simul_second", b + 1, 32'h701);

    // reset mid-frame with two frames buffered
    i_book_is_busy = 1'b1;
    send_frame(32'h801);
    send_frame(32'h901);
    for (int k = 0; k < 4; k++) send_word(32'hA01 + k, 1'b0);
    check_eq("pre_rst_count", o_frame_count, 2);
    i_reset_n = 1'b0;
    #1;
    check_eq("mid_rst_reg1", o_reg_1, 0);
    check_eq("mid_rst_regs_or", |{o_reg_8, o_reg_7, o_reg_6, o_reg_5, o_reg_4, o_reg_3, o_reg_2}, 0);
    check_eq("mid_rst_count", o_frame_count, 0);
    check_eq("mid_rst_valid", o_valid, 0);
    check_eq("mid_rst_err", o_frame_err, 0);
    check_eq("mid_rst_ready", o_word_ready, 0);
    e0 = err_cnt;
    b  = fq.size();
    repeat (3) @(posedge i_clk);
    #1;
    i_reset_n      = 1'b1;
    i_book_is_busy = 1'b0;
    @(posedge i_clk); #1;
    send_frame(32'hF01);
    wait_frames(b + 1);
    repeat (6) @(posedge i_clk);
    #1;
    check_eq("post_rst_nframes", fq.size(), b + 1);
    check_frame("post_rst_data", b, 32'hF01);
    check_eq("post_rst_errs", err_cnt - e0, 0);
    check_eq("post_rst_count", o_frame_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
